jk_updown_counter: RTL and testbench
====================================

Name: jk_updown_counter

Overview:
- Synchronous modulo-N up/down counter built from a bank of JK flip-flop cells.
- Holds the excitation logic that sits directly upstream of the JK cells: it turns the count command into per-bit J/K pairs, and the cells hold the state.
- Main use is timing and digit counting in the project datapath (seconds, BCD digits).
- Counters cascade through tc/carry_out.

Parameters:
- WIDTH, 4, number of state bits and JK cells.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: state clears while reset=0.
- enable  input  1  count enable; advances the count one step per clock.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value loaded when load=1.
- count  output  WIDTH  current state (JK cell q outputs).
- tc  output  1  terminal count for the current direction (combinational).
- carry_out  output  1  tc & enable; drives the enable of the next cascaded stage.

Behaviour:
- Reset:
  - reset=0 immediately forces count=0, independent of clock.
  - With count=0, tc=~up, and carry_out=~up & enable.
  - Deasserting reset mid-operation resumes counting from 0 at the next rising edge.
- Priority on each rising edge: reset (async) > load > enable > hold.
- Load:
  - load=1 gives count <= load_value on that edge, with 1-cycle latency.
  - If load_value >= MODULUS, count <= MODULUS-1 (clamp).
  - load overrides enable. carry_out still reflects tc & enable combinationally in that cycle.
- Count:
  - enable=1, up=1: count <= count+1. At MODULUS-1 it wraps to 0.
  - enable=1, up=0: count <= count-1. At 0 it wraps to MODULUS-1.
  - enable=0 and load=0: count holds.
- Excitation (required structure):
  - next = computed next state; toggle = count ^ next.
  - Counting: J[i]=K[i]=toggle[i].
  - Load: J[i]=next[i], K[i]=~next[i].
  - Hold: J=K=0.
  - No behavioural "count <= next" register; state lives only in the JK cells.
- tc:
  - 1 when (up & count==MODULUS-1) or (~up & count==0).
  - Independent of enable; changes immediately when up changes.
- Out-of-range state (count >= MODULUS, reachable only via X/corruption):
  - Next count with enable=1 is 0 for up and MODULUS-1 for down.
- Width rules:
  - All compares are at WIDTH bits. MODULUS-1 is a WIDTH-bit constant.
  - When MODULUS = 2**WIDTH, natural wrap applies and no compare is needed.

Optional Feature:
- Macro: JK_COUNTER_SATURATE_EN.
- Defined:
  - Counting stops at the terminal value instead of wrapping. Up holds at MODULUS-1; down holds at 0, with J=K=0 in that case.
  - tc and carry_out behave as without the macro. Cascaded stages therefore still see one carry per enabled cycle at the terminal value.
  - Load is unaffected.
- Undefined: wrap-around as described in Behaviour.

Decomposition:
- Shared package (project-wide):
  - JK encoding constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - Function clamp_mod(value, modulus).
- Sub-module jk_cell:
  - Single JK flip-flop with active-low async reset; ports clock, reset, j, k, q.
  - Instantiated WIDTH times via generate.
  - Excitation and tc logic live in jk_updown_counter.

Test Plan:
1. Reset: drive reset=0 mid-count at count=7, asynchronously between edges -> count=0 before the next edge. Release reset, enable=1, up=1 -> count=1 after one edge.
2. Up-count wrap (MODULUS=10): start at 0, enable=1, up=1 for 12 edges -> sequence 1..9,0,1,2. tc=1 only while count=9. carry_out=1 only in that cycle.
3. Down-count wrap: load_value=1, load=1, then enable=1, up=0 for 3 edges -> 1,0,9,8. tc=1 while count=0.
4. Load priority and clamp:
   - load=1, enable=1, load_value=4 -> count=4, with no increment.
   - load_value=13 -> count=9.
5. Hold and cascade: two instances with the low stage's carry_out driving the high stage's enable; count 25 edges from 00 -> high=2, low=5. High advances exactly on the low 9->0 edges.
6. JK_COUNTER_SATURATE_EN defined: count up 15 edges from 0 -> count stays 9, tc stays 1. Then up=0 for 12 edges -> stays 0.

Source files
------------

// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK-based counter family: JK excitation codes,
// the counter's per-edge operating mode and the load clamp helper.
package jk_updown_counter_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_COUNT = 2'b10
    } mode_t;

    // Values at or above the modulus collapse onto the top of the range.
    function automatic int unsigned clamp_mod(input int unsigned value,
                                              input int unsigned modulus);
        return (value >= modulus) ? modulus - 1 : value;
    endfunction

endpackage

// File: rtl/jk_updown_counter_jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset; one per counter bit.
module jk_cell
    import jk_updown_counter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    // NOTE: state registers use non-blocking assignment so every cell samples
    // the pre-edge excitation regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:  q <= q;
                JK_RESET: q <= 1'b0;
                JK_SET:   q <= 1'b1;
                default:  q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter whose state lives in a bank of JK cells.
// Define JK_COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] MAX_COUNT  = WIDTH'(MODULUS - 1);
    localparam bit               FULL_RANGE = (MODULUS == (1 << WIDTH));

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_updown_counter: MODULUS out of range for WIDTH");
    end

    mode_t            mode;
    logic [WIDTH-1:0] inc_value;
    logic [WIDTH-1:0] dec_value;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             at_max;
    logic             at_zero;
    logic             out_of_range;

    assign at_max       = (count == MAX_COUNT);
    assign at_zero      = (count == '0);
    assign out_of_range = FULL_RANGE ? 1'b0 : (count > MAX_COUNT);

    assign tc        = up ? at_max : at_zero;
    assign carry_out = tc & enable;

    // Step values; an out-of-range state re-enters at the start of the direction.
    always_comb begin
        inc_value = count + WIDTH'(1);
        dec_value = count - WIDTH'(1);
        if (!FULL_RANGE) begin
            if (at_max || out_of_range) inc_value = '0;
            if (at_zero || out_of_range) dec_value = MAX_COUNT;
        end
`ifdef JK_COUNTER_SATURATE_EN
        if (at_max)  inc_value = count;
        if (at_zero) dec_value = count;
`endif
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the priority chain can leave a latch behind.
    always_comb begin
        mode       = MODE_HOLD;
        next_count = count;
        if (load) begin
            mode       = MODE_LOAD;
            next_count = WIDTH'(clamp_mod(32'(load_value), MODULUS));
        end else if (enable) begin
            mode       = MODE_COUNT;
            next_count = up ? inc_value : dec_value;
        end
    end

    assign toggle = count ^ next_count;

    always_comb begin
        j = '0;
        k = '0;
        case (mode)
            MODE_LOAD: begin
                j = next_count;
                k = ~next_count;
            end
            MODE_COUNT: begin
                j = toggle;
                k = toggle;
            end
            default: begin
                j = '0;
                k = '0;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clock (clock),
            .reset (reset),
            .j     (j[i]),
            .k     (k[i]),
            .q     (count[i])
        );
    end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Scoreboard bench: stimulus pushes expectations from a modular-arithmetic model,
// a monitor pops and compares tc/carry before each edge and counts after it.
module tb_jk_updown_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         up;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] count;
    logic         tc;
    logic         carry_out;
    logic [W-1:0] hi_count;
    logic         hi_tc;
    logic         hi_carry;

    jk_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tc         (tc),
        .carry_out  (carry_out)
    );

    // High digit of a two-stage cascade, enabled by the low stage's carry.
    jk_updown_counter #(.WIDTH(W), .MODULUS(M)) dut_hi (
        .clock      (clock),
        .reset      (reset),
        .enable     (carry_out),
        .up         (up),
        .load       (load),
        .load_value ('0),
        .count      (hi_count),
        .tc         (hi_tc),
        .carry_out  (hi_carry)
    );

    always #5 clock = ~clock;

    typedef struct {
        int lo;
        int hi;
        bit tc;
        bit carry;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   st     = 0;
    int   hi_st  = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int advance(input int s, input bit u);
`ifdef JK_COUNTER_SATURATE_EN
        if (u) return (s >= M - 1) ? M - 1 : s + 1;
        return (s == 0) ? 0 : s - 1;
`else
        return u ? (s + 1) % M : (s + M - 1) % M;
`endif
    endfunction

    task automatic step(input bit en, input bit u, input bit ld, input int lv);
        exp_t e;
        @(negedge clock);
        enable     = en;
        up         = u;
        load       = ld;
        load_value = W'(lv);
        #2;
        e.tc    = u ? (st == M - 1) : (st == 0);
        e.carry = e.tc && en;
        if (ld) begin
            st    = (lv < M) ? lv : M - 1;
            hi_st = 0;
        end else begin
            if (e.carry) hi_st = advance(hi_st, u);
            if (en) st = advance(st, u);
        end
        e.lo = st;
        e.hi = hi_st;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("tc", int'(tc), int'(e.tc));
                check("carry_out", int'(carry_out), int'(e.carry));
                @(posedge clock);
                #1;
                check("count", int'(count), e.lo);
                check("hi_count", int'(hi_count), e.hi);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        reset      = 1'b0;
        enable     = 1'b0;
        up         = 1'b1;
        load       = 1'b0;
        load_value = '0;
        #12;
        check("reset_count", int'(count), 0);
        check("reset_tc_up", int'(tc), 0);
        check("reset_carry_up", int'(carry_out), 0);
        up     = 1'b0;
        enable = 1'b1;
        #1;
        check("reset_tc_down", int'(tc), 1);
        check("reset_carry_down", int'(carry_out), 1);
        @(posedge clock);
        #1;
        check("reset_hold_count", int'(count), 0);
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        up     = 1'b1;

        // Up-count wrap through 9 -> 0.
        step(1'b0, 1'b1, 1'b1, 0);
        repeat (12) step(1'b1, 1'b1, 1'b0, 0);

        // Down-count wrap from 1.
        step(1'b0, 1'b0, 1'b1, 1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 0);

        // Load beats enable; oversize values clamp.
        step(1'b1, 1'b1, 1'b1, 4);
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 13);
        step(1'b1, 1'b1, 1'b1, 15);
        step(1'b0, 1'b0, 1'b0, 0);

        // Cascade: 25 edges from 00.
        step(1'b0, 1'b1, 1'b1, 0);
        repeat (25) step(1'b1, 1'b1, 1'b0, 0);
        @(posedge clock);
        #2;
        check("cascade_low", int'(count), 5);
        check("cascade_high", int'(hi_count), 2);

        // Long up then down run: saturates at the ends when built that way.
        step(1'b0, 1'b1, 1'b1, 0);
        repeat (15) step(1'b1, 1'b1, 1'b0, 0);
        repeat (12) step(1'b1, 1'b0, 1'b0, 0);

        // Asynchronous reset between edges at count 7.
        step(1'b0, 1'b1, 1'b1, 6);
        step(1'b1, 1'b1, 1'b0, 0);
        @(negedge clock);
        enable = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_count", int'(count), 0);
        check("async_reset_hi", int'(hi_count), 0);
        check("async_reset_tc", int'(tc), 0);
        st    = 0;
        hi_st = 0;
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
